al_spi_flash_seq: RTL and testbench



---
 rtl/al_spi_flash_pkg.sv | 32 +++
 rtl/al_spi_flash_poll_timer.sv | 41 ++++
 rtl/al_spi_flash_seq.sv | 206 ++++++++++++++++++++
 tb/tb_al_spi_flash_seq.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/al_spi_flash_pkg.sv
// Shared encodings for the SPI flash command sequencer: host ops, response codes,
// FSM states and the standard flash opcodes.
package al_spi_flash_pkg;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_PROGRAM = 2'd1;
    localparam logic [1:0] OP_ERASE   = 2'd2;
    localparam logic [1:0] OP_RAW     = 2'd3;

    localparam logic [1:0] RESP_OK      = 2'b00;
    localparam logic [1:0] RESP_TIMEOUT = 2'b01;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WREN = 3'd1;
    localparam logic [2:0] ST_MAIN = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_POLL = 3'd4;
    localparam logic [2:0] ST_RESP = 3'd5;

    localparam logic [7:0] OPC_WREN      = 8'h06;
    localparam logic [7:0] OPC_RDSR      = 8'h05;
    localparam logic [7:0] OPC_READ      = 8'h03;
    localparam logic [7:0] OPC_FAST_READ = 8'h0B;
    localparam logic [7:0] OPC_PP        = 8'h02;
    localparam logic [7:0] OPC_SE        = 8'h20;

    // Program and erase modify the array, so they need WREN first and WIP polling after.
    function automatic logic op_is_write(input logic [1:0] op);
        return (op == OP_PROGRAM) || (op == OP_ERASE);
    endfunction

endpackage

// File: rtl/al_spi_flash_poll_timer.sv
// Inter-poll gap down-counter and saturating status-poll counter for the flash sequencer.
module al_spi_flash_poll_timer
    import al_spi_flash_pkg::*;
#(
    parameter logic [7:0]  POLL_GAP = 8'd16,
    parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_poll_clear,
    input  logic i_poll_inc,
    input  logic i_gap_load,
    output logic o_gap_done,
    output logic o_poll_at_max
);

    logic [7:0]  r_gap_cnt;
    logic [23:0] r_poll_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_cnt  <= 8'd0;
            r_poll_cnt <= 24'd0;
        end else begin
            if (i_gap_load) begin
                r_gap_cnt <= POLL_GAP;
            end else if (r_gap_cnt != 8'd0) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end
            if (i_poll_clear) begin
                r_poll_cnt <= 24'd0;
            end else if (i_poll_inc && (r_poll_cnt != 24'hFFFFFF)) begin
                r_poll_cnt <= r_poll_cnt + 24'd1;
            end
        end
    end

    assign o_gap_done    = (r_gap_cnt == 8'd0);
    assign o_poll_at_max = (r_poll_cnt == POLL_MAX);

endmodule

// File: rtl/al_spi_flash_seq.sv
// Flash command sequencer: expands one host request into WREN / main command / RDSR polling
// transactions on the SPI engine command port.
module al_spi_flash_seq
    import al_spi_flash_pkg::*;
#(
    parameter logic [7:0]  CMD_WREN   = 8'h06,
    parameter logic [7:0]  CMD_RDSR   = 8'h05,
    parameter int unsigned STATUS_LSB = 24,
    parameter logic [7:0]  POLL_GAP   = 8'd16,
    parameter logic [23:0] POLL_MAX   = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_cmd,
    input  logic [23:0] req_addr,
    input  logic [5:0]  req_len,
    output logic        resp_valid,
    output logic [1:0]  resp_status,
    output logic        e_valid,
    input  logic        e_ready,
    output logic [7:0]  e_cmd,
    output logic [31:0] e_edata,
    output logic [1:0]  e_edata_wr_sz,
    output logic        e_edata_wr_valid,
    output logic [3:0]  e_dummy_sz,
    output logic        e_dummy_valid,
    output logic        e_mem_valid,
    output logic [5:0]  e_mem_length,
    output logic        e_mem_wr,
    input  logic [31:0] snp_wdata,
    input  logic        snp_wvalid,
    input  logic        snp_wready
);

    logic [2:0]  r_state;
    logic [1:0]  r_op;
    logic [7:0]  r_cmd;
    logic [23:0] r_addr;
    logic [5:0]  r_len;
    logic [1:0]  r_status;
    logic        r_skip;
    logic        r_captured;
    logic        r_wip;

    logic [2:0] w_state_nxt;
    logic [1:0] w_status_nxt;
    logic       w_accept;
    logic       w_hs;
    logic       w_snp_hit;
    logic       w_wip;
    logic       w_poll_inc;
    logic       w_gap_load;
    logic       w_gap_done;
    logic       w_poll_at_max;
    logic       w_unused_snp;

    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    assign w_hs      = e_valid && e_ready;
    assign w_snp_hit = (r_state == ST_POLL) && snp_wvalid && snp_wready && !r_captured;
    // A poll that finishes without any status word is treated as still busy.
    assign w_wip     = r_captured ? r_wip : (w_snp_hit ? snp_wdata[STATUS_LSB] : 1'b1);
    assign w_unused_snp = ^snp_wdata;

    al_spi_flash_poll_timer #(
        .POLL_GAP (POLL_GAP),
        .POLL_MAX (POLL_MAX)
    ) u_poll_timer (
        .clk           (clk),
        .rst           (rst),
        .i_poll_clear  (w_accept),
        .i_poll_inc    (w_poll_inc),
        .i_gap_load    (w_gap_load),
        .o_gap_done    (w_gap_done),
        .o_poll_at_max (w_poll_at_max)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_poll_inc   = 1'b0;
        w_gap_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt  = op_is_write(req_op) ? ST_WREN : ST_MAIN;
                    w_status_nxt = RESP_OK;
                end
            end
            ST_WREN: if (w_hs) w_state_nxt = ST_MAIN;
            ST_MAIN: begin
                if (w_hs) begin
                    if (op_is_write(r_op)) begin
                        w_state_nxt = ST_POLL;
                        w_poll_inc  = 1'b1;
                    end else begin
                        w_state_nxt  = ST_RESP;
                        w_status_nxt = RESP_OK;
                    end
                end
            end
            ST_POLL: begin
                if (w_hs) begin
                    if (!w_wip) begin
                        w_state_nxt  = ST_RESP;
                        w_status_nxt = RESP_OK;
                    end else if (w_poll_at_max) begin
                        w_state_nxt  = ST_RESP;
                        w_status_nxt = RESP_TIMEOUT;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_gap_load  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_POLL;
                    w_poll_inc  = 1'b1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_skip forces one idle cycle on e_valid after every engine completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= 2'd0;
            r_cmd      <= 8'd0;
            r_addr     <= 24'd0;
            r_len      <= 6'd0;
            r_status   <= RESP_OK;
            r_skip     <= 1'b0;
            r_captured <= 1'b0;
            r_wip      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            r_skip   <= w_hs;
            if (w_accept) begin
                r_op   <= req_op;
                r_cmd  <= req_cmd;
                r_addr <= req_addr;
                r_len  <= req_len;
            end
            if (r_state != ST_POLL) begin
                r_captured <= 1'b0;
            end else if (w_snp_hit) begin
                r_captured <= 1'b1;
                r_wip      <= snp_wdata[STATUS_LSB];
            end
        end
    end

    always_comb begin
        req_ready        = (r_state == ST_IDLE);
        resp_valid       = (r_state == ST_RESP);
        resp_status      = (r_state == ST_RESP) ? r_status : 2'b00;
        e_valid          = ((r_state == ST_WREN) || (r_state == ST_MAIN) ||
                            (r_state == ST_POLL)) && !r_skip;
        e_cmd            = 8'd0;
        e_edata          = 32'd0;
        e_edata_wr_sz    = 2'd0;
        e_edata_wr_valid = 1'b0;
        e_dummy_sz       = 4'd0;
        e_dummy_valid    = 1'b0;
        e_mem_valid      = 1'b0;
        e_mem_length     = 6'd0;
        e_mem_wr         = 1'b0;
        case (r_state)
            ST_WREN: e_cmd = CMD_WREN;
            ST_MAIN: begin
                e_cmd = r_cmd;
                if (r_op != OP_RAW) begin
                    e_edata          = {r_addr, 8'h00};
                    e_edata_wr_sz    = 2'd2;
                    e_edata_wr_valid = 1'b1;
                end
                if (r_op == OP_READ) begin
                    e_mem_valid  = 1'b1;
                    e_mem_wr     = 1'b1;
                    e_mem_length = r_len;
                    if (r_cmd == OPC_FAST_READ) begin
                        e_dummy_valid = 1'b1;
                        e_dummy_sz    = 4'd7;
                    end
                end else if (r_op == OP_PROGRAM) begin
                    e_mem_valid  = 1'b1;
                    e_mem_length = r_len;
                end
            end
            ST_POLL: begin
                e_cmd       = CMD_RDSR;
                e_mem_valid = 1'b1;
                e_mem_wr    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_al_spi_flash_seq.sv
// Self-checking bench for al_spi_flash_seq: randomized engine model plus a transaction-list
// reference model of the expected WREN / main / RDSR sequence.
module tb_al_spi_flash_seq;
    import al_spi_flash_pkg::*;

    localparam logic [7:0]  TB_GAP = 8'd16;
    localparam logic [23:0] TB_MAX = 24'd4;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] edata;
        logic [1:0]  wr_sz;
        logic        ed_v;
        logic [3:0]  dsz;
        logic        d_v;
        logic        m_v;
        logic [5:0]  mlen;
        logic        m_wr;
    } txn_t;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_cmd;
    logic [23:0] req_addr;
    logic [5:0]  req_len;
    logic        resp_valid;
    logic [1:0]  resp_status;
    logic        e_valid, e_ready;
    logic [7:0]  e_cmd;
    logic [31:0] e_edata;
    logic [1:0]  e_edata_wr_sz;
    logic        e_edata_wr_valid;
    logic [3:0]  e_dummy_sz;
    logic        e_dummy_valid, e_mem_valid;
    logic [5:0]  e_mem_length;
    logic        e_mem_wr;
    logic [31:0] snp_wdata;
    logic        snp_wvalid, snp_wready;

    al_spi_flash_seq #(
        .POLL_GAP (TB_GAP),
        .POLL_MAX (TB_MAX)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_cmd          (req_cmd),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .resp_valid       (resp_valid),
        .resp_status      (resp_status),
        .e_valid          (e_valid),
        .e_ready          (e_ready),
        .e_cmd            (e_cmd),
        .e_edata          (e_edata),
        .e_edata_wr_sz    (e_edata_wr_sz),
        .e_edata_wr_valid (e_edata_wr_valid),
        .e_dummy_sz       (e_dummy_sz),
        .e_dummy_valid    (e_dummy_valid),
        .e_mem_valid      (e_mem_valid),
        .e_mem_length     (e_mem_length),
        .e_mem_wr         (e_mem_wr),
        .snp_wdata        (snp_wdata),
        .snp_wvalid       (snp_wvalid),
        .snp_wready       (snp_wready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    txn_t       log_q[$];
    txn_t       exp_q[$];
    int         start_q[$];
    int         hs_q[$];
    logic [1:0] resp_q[$];
    logic [1:0] exp_status;
    int         poll_codes[$];
    bit         noise_en = 1'b0;
    int         stable_bad = 0;

    function automatic txn_t cur_txn();
        txn_t t;
        t.cmd = e_cmd; t.edata = e_edata; t.wr_sz = e_edata_wr_sz; t.ed_v = e_edata_wr_valid;
        t.dsz = e_dummy_sz; t.d_v = e_dummy_valid; t.m_v = e_mem_valid;
        t.mlen = e_mem_length; t.m_wr = e_mem_wr;
        return t;
    endfunction

    // Engine model. Poll codes: 0 = ready, 1 = busy, 2 = no status word, 3 = busy then ready word.
    initial begin
        int   wait_cnt;
        int   code;
        txn_t cur;
        wait_cnt = -1; code = 1; cur = '0;
        e_ready = 1'b0; snp_wvalid = 1'b0; snp_wready = 1'b1; snp_wdata = 32'd0;
        forever begin
            @(negedge clk);
            e_ready = 1'b0; snp_wvalid = 1'b0; snp_wdata = $urandom;
            if (resp_valid) resp_q.push_back(resp_status);
            if (rst) begin
                wait_cnt = -1;
            end else if (e_valid) begin
                if (wait_cnt < 0) begin
                    cur = cur_txn();
                    start_q.push_back(cyc);
                    wait_cnt = $urandom_range(1, 3);
                    code = 1;
                    if (e_cmd == OPC_RDSR) begin
                        code = (poll_codes.size() > 0) ? poll_codes.pop_front() : 1;
                        if (code == 3) wait_cnt = 2;
                    end
                end else if (cur !== cur_txn()) begin
                    stable_bad++;
                end
                if (wait_cnt == 0) begin
                    e_ready = 1'b1;
                    log_q.push_back(cur);
                    hs_q.push_back(cyc);
                    wait_cnt = -1;
                end else begin
                    if (e_cmd == OPC_RDSR) begin
                        if (code == 3) begin
                            snp_wvalid = 1'b1; snp_wdata[24] = (wait_cnt == 2);
                        end else if (wait_cnt == 1 && code != 2) begin
                            snp_wvalid = 1'b1; snp_wdata[24] = (code == 1);
                        end
                    end else if (noise_en) begin
                        snp_wvalid = 1'b1; snp_wdata[24] = 1'b0;
                    end
                    wait_cnt--;
                end
            end
        end
    end

    // Reference: ordered list of engine transactions and the final status for one request.
    function automatic void model(input logic [1:0] op, input logic [7:0] cmd,
                                  input logic [23:0] addr, input logic [5:0] len,
                                  input int codes[$]);
        txn_t t;
        bit   busy;
        exp_q.delete();
        exp_status = RESP_OK;
        if (op == OP_PROGRAM || op == OP_ERASE) begin
            t = '0; t.cmd = 8'h06; exp_q.push_back(t);
        end
        t = '0; t.cmd = cmd;
        if (op != OP_RAW) begin t.edata = {addr, 8'h00}; t.wr_sz = 2'd2; t.ed_v = 1'b1; end
        if (op == OP_READ) begin
            t.m_v = 1'b1; t.m_wr = 1'b1; t.mlen = len;
            if (cmd == 8'h0B) begin t.d_v = 1'b1; t.dsz = 4'd7; end
        end
        if (op == OP_PROGRAM) begin t.m_v = 1'b1; t.mlen = len; end
        exp_q.push_back(t);
        if (op == OP_PROGRAM || op == OP_ERASE) begin
            for (int k = 1; k <= int'(TB_MAX); k++) begin
                t = '0; t.cmd = 8'h05; t.m_v = 1'b1; t.m_wr = 1'b1; exp_q.push_back(t);
                busy = (k <= codes.size()) ? (codes[k-1] != 0) : 1'b1;
                if (!busy) break;
                if (k == int'(TB_MAX)) exp_status = RESP_TIMEOUT;
            end
        end
    endfunction

    task automatic run_req(input logic [1:0] op, input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [5:0] len, input int codes[$],
                           output int acc_cyc, output bit done);
        int n;
        log_q.delete(); start_q.delete(); hs_q.delete(); resp_q.delete();
        poll_codes = codes;
        model(op, cmd, addr, len, codes);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_op = op; req_cmd = cmd; req_addr = addr; req_len = len;
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0; req_op = $urandom; req_cmd = $urandom; req_addr = $urandom;
        n = 0;
        while (resp_q.size() == 0 && n < 2000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        done = (resp_q.size() > 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || e_valid !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b e_valid=%b resp_valid=%b want 1 0 0",
                     req_ready, e_valid, resp_valid);
        end
        checks++;
        if (cur_txn() !== txn_t'(0) || resp_status !== 2'b00) begin
            errors++;
            $display("FAIL reset_fields: txn=%h status=%b want 0", cur_txn(), resp_status);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || e_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ready=%b e_valid=%b want 1 0", req_ready, e_valid);
        end
    endtask

    task automatic test_read_family();
        int acc; bit done;
        logic [1:0] ops[4]  = '{OP_READ, OP_READ, OP_RAW, OP_READ};
        logic [7:0] cmds[4] = '{8'h03, 8'h0B, 8'hB9, 8'h03};
        logic [23:0] adr[4] = '{24'h123456, 24'hABCDEF, 24'h000000, 24'h000100};
        logic [5:0] lens[4] = '{6'd3, 6'd0, 6'd0, 6'd63};
        int none[$];
        for (int c = 0; c < 4; c++) begin
            noise_en = (c == 3);
            run_req(ops[c], cmds[c], adr[c], lens[c], none, acc, done);
            noise_en = 1'b0;
            checks++;
            if (!done || resp_q.size() != 1 || resp_q[0] !== exp_status) begin
                errors++;
                $display("FAIL read_resp[%0d]: count=%0d status=%b want 1 %b", c, resp_q.size(),
                         done ? resp_q[0] : 2'bxx, exp_status);
            end
            checks++;
            if (log_q.size() != exp_q.size() || start_q.size() == 0 || start_q[0] - acc != 1) begin
                errors++;
                $display("FAIL read_count[%0d]: txns=%0d want %0d (latency check)", c,
                         log_q.size(), exp_q.size());
            end
            for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL read_txn[%0d.%0d]: got %h want %h", c, i, log_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_poll_sequences();
        int acc; bit done; int codes[$]; int want;
        logic [1:0] op;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin op = OP_ERASE;   codes = '{1, 1, 0}; end
                1: begin op = OP_PROGRAM; codes = {};         end
                2: begin op = OP_ERASE;   codes = '{2, 0};    end
                default: begin op = OP_PROGRAM; codes = '{3, 3, 0}; end
            endcase
            run_req(op, (op == OP_ERASE) ? 8'h20 : 8'h02, $urandom, $urandom, codes, acc, done);
            checks++;
            if (!done || resp_q.size() != 1 || resp_q[0] !== exp_status) begin
                errors++;
                $display("FAIL poll_resp[%0d]: count=%0d status=%b want 1 %b", c, resp_q.size(),
                         done ? resp_q[0] : 2'bxx, exp_status);
            end
            checks++;
            if (log_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL poll_count[%0d]: txns=%0d want %0d", c, log_q.size(), exp_q.size());
            end
            for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL poll_txn[%0d.%0d]: got %h want %h", c, i, log_q[i], exp_q[i]);
                end
            end
            for (int i = 1; i < start_q.size() && i < hs_q.size(); i++) begin
                want = (log_q[i].cmd == 8'h05 && log_q[i-1].cmd == 8'h05) ? int'(TB_GAP) + 2 : 2;
                checks++;
                if (start_q[i] - hs_q[i-1] != want) begin
                    errors++;
                    $display("FAIL poll_gap[%0d.%0d]: got %0d cycles want %0d", c, i,
                             start_q[i] - hs_q[i-1], want);
                end
            end
        end
    endtask

    task automatic test_random();
        int acc; bit done; int codes[$]; int n;
        logic [1:0] op; logic [7:0] cmd;
        for (int it = 0; it < 10; it++) begin
            op = 2'($urandom_range(0, 3));
            case (op)
                OP_READ:    cmd = $urandom_range(0, 1) ? 8'h0B : 8'h03;
                OP_PROGRAM: cmd = 8'h02;
                OP_ERASE:   cmd = 8'h20;
                default:    cmd = $urandom;
            endcase
            codes = {};
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) codes.push_back($urandom_range(0, 3));
            noise_en = $urandom_range(0, 1);
            run_req(op, cmd, $urandom, $urandom, codes, acc, done);
            noise_en = 1'b0;
            checks++;
            if (!done || resp_q.size() != 1 || resp_q[0] !== exp_status ||
                log_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_resp[%0d]: resps=%0d txns=%0d want 1 %0d status want %b", it,
                         resp_q.size(), log_q.size(), exp_q.size(), exp_status);
            end
            for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_txn[%0d.%0d]: got %h want %h", it, i, log_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (stable_bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d field changes while waiting want 0", stable_bad);
        end
    endtask

    task automatic test_mid_reset();
        int n; int acc; bit done; int none[$];
        poll_codes = {};
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_op = OP_ERASE; req_cmd = 8'h20; req_addr = 24'h010000;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(e_valid && e_cmd == OPC_RDSR) && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL midrst_reach: no RDSR seen within 300 cycles");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (e_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 ||
            cur_txn() !== txn_t'(0)) begin
            errors++;
            $display("FAIL midrst_outputs: e_valid=%b ready=%b resp=%b txn=%h want 0 1 0 0",
                     e_valid, req_ready, resp_valid, cur_txn());
        end
        resp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (resp_q.size() != 0 || e_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_quiet: resps=%0d e_valid=%b ready=%b want 0 0 1",
                     resp_q.size(), e_valid, req_ready);
        end
        run_req(OP_READ, 8'h03, 24'h123456, 6'd3, none, acc, done);
        checks++;
        if (!done || resp_q.size() != 1 || resp_q[0] !== RESP_OK || log_q.size() != 1 ||
            log_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL midrst_read: resps=%0d txns=%0d want 1 1 with ok status",
                     resp_q.size(), log_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_cmd = 8'd0; req_addr = 24'd0;
        req_len = 6'd0;
        test_reset();
        test_read_family();
        test_poll_sequences();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
